ahb_lite_cmd_master: RTL and testbench



---
 rtl/ahb_lite_cmd_master.sv | 246 ++++++++++++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready command in, one AHB transfer, response out.
// Optional data-phase timeout is built when AHB_MST_TIMEOUT_EN is defined.
module ahb_lite_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic [1:0]  HRESP
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   state_e      state_q, state_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;

`ifdef AHB_MST_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             unused_s;
   assign unused_s = HRESP[1];
`else
   logic             unused_s;
   assign unused_s = ^{HRESP[1], 32'(TIMEOUT_CYCLES)};
`endif

   // Size/alignment legality: byte always, halfword even, word on a 4-byte boundary.
   function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         3'd0:    ok = 1'b1;
         3'd1:    ok = ~addr_lo[0];
         3'd2:    ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // State and output registers; every bus and response output comes straight from a flop.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= S_IDLE;
         htrans_q    <= TRANS_IDLE;
         haddr_q     <= 32'h0000_0000;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         hwdata_q    <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
`ifdef AHB_MST_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
`ifdef AHB_MST_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   // Next-state and next-output logic for the IDLE/ADDR/DATA/RESP sequence.
   always_comb begin
      state_d     = state_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cmd_ready_d = cmd_ready_q;
      busy_d      = busy_q;
`ifdef AHB_MST_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               hwrite_d    = cmd_write;
               haddr_d     = cmd_addr;
               hsize_d     = cmd_size;
               wdata_d     = cmd_wdata;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                  state_d  = S_ADDR;
                  htrans_d = TRANS_NONSEQ;
               end else begin
                  // Rejected locally: no bus activity, error response next cycle.
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0000_0000;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ADDR: begin
            if (HREADY) begin
               state_d  = S_DATA;
               htrans_d = TRANS_IDLE;
               hwdata_d = hwrite_q ? wdata_q : 32'h0000_0000;
               err_d    = 1'b0;
`ifdef AHB_MST_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end else begin
               state_d = S_ADDR;
            end
         end

         S_DATA: begin
            if (HREADY) begin
               state_d     = S_RESP;
               hwdata_d    = 32'h0000_0000;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q | HRESP[0];
               rsp_rdata_d = (!hwrite_q && !(err_q | HRESP[0])) ? HRDATA : 32'h0000_0000;
            end else begin
               err_d = err_q | HRESP[0];
`ifdef AHB_MST_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d       = S_RESP;
                  hwdata_d      = 32'h0000_0000;
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = 32'h0000_0000;
               end else begin
                  state_d = S_DATA;
               end
`else
               state_d = S_DATA;
`endif
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0000_0000;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
`ifdef AHB_MST_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end else begin
               state_d = S_RESP;
            end
         end

         default: begin
            state_d     = S_IDLE;
            htrans_d    = TRANS_IDLE;
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HWDATA    = hwdata_q;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
`ifdef AHB_MST_TIMEOUT_EN
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed self-checking bench for ahb_lite_cmd_master; edges are counted from command acceptance.
module tb_ahb_lite_cmd_master;

   logic        HCLK, HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS, HRESP;
   logic        HWRITE, HMASTLOCK, HREADY;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   int tests = 0;
   int fails = 0;

   ahb_lite_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // Present one command; it is accepted on the next edge (edge 0).
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      #12;
      tests++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
      tests++; if (HADDR !== 32'h0) begin fails++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
      tests++; if ({rsp_valid, rsp_err, rsp_timeout, busy} !== 4'b0000) begin fails++; $display("FAIL reset_rsp: got %b want 0000", {rsp_valid, rsp_err, rsp_timeout, busy}); end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      tick();
      tests++; if ({cmd_ready, busy} !== 2'b10) begin fails++; $display("FAIL reset_ready: got %b want 10", {cmd_ready, busy}); end
      tests++; if ({HBURST, HPROT, HMASTLOCK} !== 8'b000_0011_0) begin fails++; $display("FAIL consts: got %b want 00000110", {HBURST, HPROT, HMASTLOCK}); end
   endtask

   task automatic test_zero_wait_write();
      issue(1'b1, 32'h4000_0008, 3'd2, 32'h0000_A5A5);
      tests++; if ({HTRANS, HWRITE, HSIZE} !== 6'b10_1_010) begin fails++; $display("FAIL zw_addr_ctrl: got %b want 101010", {HTRANS, HWRITE, HSIZE}); end
      tests++; if (HADDR !== 32'h4000_0008) begin fails++; $display("FAIL zw_haddr: got %h want 40000008", HADDR); end
      tests++; if ({cmd_ready, busy} !== 2'b01) begin fails++; $display("FAIL zw_busy: got %b want 01", {cmd_ready, busy}); end
      tick();
      tests++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL zw_data_htrans: got %b want 00", HTRANS); end
      tests++; if (HWDATA !== 32'h0000_A5A5) begin fails++; $display("FAIL zw_hwdata: got %h want 0000a5a5", HWDATA); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL zw_early_rsp: got %b want 0", rsp_valid); end
      tick();
      tests++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin fails++; $display("FAIL zw_rsp: got %b %b %h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
      tick();
      tests++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin fails++; $display("FAIL zw_idle: got %b want 010", {rsp_valid, cmd_ready, busy}); end
   endtask

   task automatic test_read_wait();
      issue(1'b0, 32'h4000_0010, 3'd2, 32'h0);
      tick();
      HREADY = 1'b0;
      tick();
      tick();
      tests++; if ({rsp_valid, HTRANS} !== 3'b000) begin fails++; $display("FAIL rw_waiting: got %b want 000", {rsp_valid, HTRANS}); end
      HREADY = 1'b1; HRDATA = 32'h1234_5678;
      tick();
      HRDATA = 32'h0;
      tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL rw_rsp: got %b want 10", {rsp_valid, rsp_err}); end
      tests++; if (rsp_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rw_rdata: got %h want 12345678", rsp_rdata); end
      tick();
      tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rw_done: got %b want 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_error();
      issue(1'b0, 32'h4000_0020, 3'd1, 32'h0);
      HREADY = 1'b0;
      tick();
      tests++; if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0020}) begin fails++; $display("FAIL err_addr_hold: got %b %h want 10 40000020", HTRANS, HADDR); end
      HREADY = 1'b1;
      tick();
      HREADY = 1'b0; HRESP = 2'b01; HRDATA = 32'hDEAD_BEEF;
      tick();
      tests++; if ({rsp_valid, HTRANS} !== 3'b000) begin fails++; $display("FAIL err_first: got %b want 000", {rsp_valid, HTRANS}); end
      HREADY = 1'b1;
      tick();
      HRESP = 2'b00; HRDATA = 32'h0;
      tests++; if ({rsp_valid, rsp_err, HTRANS} !== 4'b1100) begin fails++; $display("FAIL err_rsp: got %b want 1100", {rsp_valid, rsp_err, HTRANS}); end
      tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL err_rdata: got %h want 0", rsp_rdata); end
      tick();
   endtask

   task automatic test_local_reject();
      issue(1'b1, 32'h4000_0002, 3'd2, 32'h1111_1111);
      tests++; if ({rsp_valid, rsp_err, HTRANS, cmd_ready} !== 5'b11000) begin fails++; $display("FAIL rej_word: got %b want 11000", {rsp_valid, rsp_err, HTRANS, cmd_ready}); end
      tick();
      issue(1'b0, 32'h0000_0000, 3'd3, 32'h0);
      tests++; if ({rsp_valid, rsp_err, HTRANS} !== 4'b1100) begin fails++; $display("FAIL rej_size3: got %b want 1100", {rsp_valid, rsp_err, HTRANS}); end
      tick();
      issue(1'b0, 32'h0000_0001, 3'd1, 32'h0);
      tests++; if ({rsp_valid, rsp_err, HTRANS} !== 4'b1100) begin fails++; $display("FAIL rej_half: got %b want 1100", {rsp_valid, rsp_err, HTRANS}); end
      tick();
      tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rej_done: got %b want 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      issue(1'b0, 32'h4000_0030, 3'd0, 32'h0);
      HRDATA = 32'hCAFE_F00D;
      tick();
      tick();
      HRDATA = 32'h0;
      for (int i = 0; i < 10; i++) begin
         tests++;
         if ({rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {3'b100, 32'hCAFE_F00D}) begin
            fails++; $display("FAIL bp_hold[%0d]: got %b %h want 100 cafef00d", i, {rsp_valid, rsp_err, cmd_ready}, rsp_rdata);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: got %b want 01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_back_to_back();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0040; cmd_size = 3'd2; cmd_wdata = 32'h0;
      tick();
      cmd_addr = 32'h4000_0044; cmd_write = 1'b1; cmd_wdata = 32'h0BAD_F00D;
      tick();
      HRESP = 2'b01; HRDATA = 32'h5555_5555;
      tick();
      HRESP = 2'b00; HRDATA = 32'h0;
      tests++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL b2b_last_err: got %b %b %h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
      tick();
      tests++; if ({cmd_ready, HTRANS} !== 3'b100) begin fails++; $display("FAIL b2b_gap: got %b want 100", {cmd_ready, HTRANS}); end
      tick();
      cmd_valid = 1'b0;
      tests++; if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h4000_0044, 1'b1}) begin fails++; $display("FAIL b2b_second: got %b %h %b want 10 40000044 1", HTRANS, HADDR, HWRITE); end
      tick();
      tick();
      tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL b2b_second_rsp: got %b want 10", {rsp_valid, rsp_err}); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 32'h4000_0050, 3'd2, 32'h7777_8888);
      tick();
      HREADY = 1'b0;
      tick();
      tests++; if ({busy, HWDATA} !== {1'b1, 32'h7777_8888}) begin fails++; $display("FAIL rm_before: got %b %h want 1 77778888", busy, HWDATA); end
      #2 HRESETn = 1'b0;
      #1;
      tests++; if ({HTRANS, HWRITE, HSIZE, busy, rsp_valid, rsp_err} !== 9'b0) begin fails++; $display("FAIL rm_ctrl: got %b want 0", {HTRANS, HWRITE, HSIZE, busy, rsp_valid, rsp_err}); end
      tests++; if ({HADDR, HWDATA, rsp_rdata} !== 96'h0) begin fails++; $display("FAIL rm_data: got %h %h %h want 0", HADDR, HWDATA, rsp_rdata); end
      HREADY = 1'b1;
      tick();
      HRESETn = 1'b1;
      tick();
      tests++; if ({cmd_ready, busy} !== 2'b10) begin fails++; $display("FAIL rm_after: got %b want 10", {cmd_ready, busy}); end
   endtask

   task automatic test_stall();
      issue(1'b0, 32'h4000_0060, 3'd2, 32'h0);
      tick();
      HREADY = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      tests++; if ({rsp_valid, busy} !== 2'b01) begin fails++; $display("FAIL stall_7: got %b want 01", {rsp_valid, busy}); end
      tick();
`ifdef AHB_MST_TIMEOUT_EN
      tests++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin fails++; $display("FAIL stall_timeout: got %b want 111", {rsp_valid, rsp_err, rsp_timeout}); end
`else
      for (int i = 0; i < 12; i++) tick();
      tests++; if ({rsp_valid, rsp_timeout, busy} !== 3'b001) begin fails++; $display("FAIL stall_hang: got %b want 001", {rsp_valid, rsp_timeout, busy}); end
`endif
      HRESETn = 1'b0;
      HREADY = 1'b1;
      tick();
      HRESETn = 1'b1;
      tick();
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
      rsp_ready = 1'b1; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 2'b00;
      test_reset();
      test_zero_wait_write();
      test_read_wait();
      test_error();
      test_local_reject();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
